pipeline_hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage ARM core.
- Generates the freeze and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers from three sources: RAW hazards, taken branches resolved in EXE, and a multi-cycle SRAM handshake in MEM.
- Holds a memory-wait state machine with a timeout fault and a saturating hazard-stall performance counter.

---
 rtl/pipeline_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: freeze/flush sequencer for the 5-stage ARM core.
// Combines RAW hazards, EXE-resolved taken branches and a multi-cycle SRAM
// handshake into PC/IF-ID/ID-EX/EX-MEM controls. Owns the memory-wait FSM
// with a sticky timeout fault and a saturating hazard-bubble counter.
// Build option: define FORWARDING_EN when the forwarding unit is present;
// the hazard check then reduces to a load-use check against EXE only.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_two_src,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_front,
  output logic             freeze_back,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             fault,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_fault;

  logic w_src1_hit, w_src2_hit, w_hz;
  logic w_ff, w_fb, w_ifl, w_idl;
  logic w_cnt_clr, w_cnt_inc, w_stall_inc, w_to_fault;

  // Counter saturates at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef FORWARDING_EN
  // Only a load in EXE cannot be forwarded in time; MEM results always can.
  assign w_src1_hit = id_valid && exe_mem_r_en && exe_wb_en && (exe_dest == id_src1);
  assign w_src2_hit = id_valid && id_two_src && exe_mem_r_en && exe_wb_en &&
                      (exe_dest == id_src2);
  logic w_unused_fwd;
  assign w_unused_fwd = &{1'b0, mem_dest, mem_wb_en};
`else
  assign w_src1_hit = id_valid &&
                      ((exe_wb_en && (exe_dest == id_src1)) ||
                       (mem_wb_en && (mem_dest == id_src1)));
  assign w_src2_hit = id_valid && id_two_src &&
                      ((exe_wb_en && (exe_dest == id_src2)) ||
                       (mem_wb_en && (mem_dest == id_src2)));
  logic w_unused_fwd;
  assign w_unused_fwd = exe_mem_r_en;
`endif
  assign w_hz = w_src1_hit || w_src2_hit;

  // Next state and Mealy controls; branch beats hazard whenever the pipe advances.
  always_comb begin
    w_next      = r_state;
    w_ff        = 1'b0;
    w_fb        = 1'b0;
    w_ifl       = 1'b0;
    w_idl       = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_stall_inc = 1'b0;
    w_to_fault  = 1'b0;
    unique case (r_state)
      RUN: begin
        if (mem_req) begin
          w_ff      = 1'b1;
          w_fb      = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = MEM_WAIT;
        end else if (branch_taken) begin
          w_ifl = 1'b1;
          w_idl = 1'b1;
        end else if (w_hz) begin
          w_ff        = 1'b1;
          w_idl       = 1'b1;
          w_stall_inc = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          w_ff      = 1'b1;
          w_fb      = 1'b1;
          w_cnt_inc = 1'b1;
          if (r_wait_cnt == WAIT_LAST) begin
            w_next     = FAULT;
            w_to_fault = 1'b1;
          end
        end else begin
          w_next = RUN;
          if (branch_taken) begin
            w_ifl = 1'b1;
            w_idl = 1'b1;
          end else if (w_hz) begin
            w_ff        = 1'b1;
            w_idl       = 1'b1;
            w_stall_inc = 1'b1;
          end
        end
      end
      FAULT: begin
        w_ff = 1'b1;
        w_fb = 1'b1;
      end
      default: w_next = RUN;
    endcase
  end

  // State, wait counter, stall counter and sticky fault flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_cnt_clr)      r_wait_cnt <= '0;
      else if (w_cnt_inc) r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_stall_inc)    r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_to_fault)     r_fault <= 1'b1;
    end
  end

  // Controls are forced low for as long as reset is held.
  assign freeze_front = w_ff  & ~rst;
  assign freeze_back  = w_fb  & ~rst;
  assign if_id_flush  = w_ifl & ~rst;
  assign id_ex_flush  = w_idl & ~rst;
  assign fault        = r_fault;
  assign state        = r_state;
  assign stall_count  = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_two_src;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic       branch_taken, mem_req, mem_ready;
  logic       freeze_front, freeze_back, if_id_flush, id_ex_flush, fault;
  logic [1:0] state;
  logic [3:0] stall_count;

  int n_pass  = 0;
  int n_total = 0;
  int exp_stall = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_two_src(id_two_src),
    .id_src1(id_src1), .id_src2(id_src2),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_front(freeze_front), .freeze_back(freeze_back),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fault(fault), .state(state), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // {freeze_front, freeze_back, if_id_flush, id_ex_flush}
  wire [3:0] outs = {freeze_front, freeze_back, if_id_flush, id_ex_flush};

  typedef struct packed {
    logic       v, two;
    logic [3:0] s1, s2, ed;
    logic       ewb, emr;
    logic [3:0] md;
    logic       mwb, br;
    logic [3:0] e_full, e_fwd;
  } vec_t;

  vec_t tbl [0:10];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_two_src = 0; id_src1 = 0; id_src2 = 0;
    exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
    mem_dest = 0; mem_wb_en = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic load_use_hz();
    id_valid = 1; id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1; exe_mem_r_en = 1;
  endtask

  initial begin
    //            v  two s1 s2 ed ewb emr md mwb br  full     fwd
    tbl[0]  = '{1'b0,1'b0,4'd0,4'd0,4'd0,1'b0,1'b0,4'd0,1'b0,1'b0,4'b0000,4'b0000};
    tbl[1]  = '{1'b1,1'b0,4'd3,4'd0,4'd3,1'b1,1'b0,4'd0,1'b0,1'b0,4'b1001,4'b0000};
    tbl[2]  = '{1'b1,1'b0,4'd3,4'd0,4'd3,1'b1,1'b1,4'd0,1'b0,1'b0,4'b1001,4'b1001};
    tbl[3]  = '{1'b1,1'b1,4'd0,4'd5,4'd0,1'b0,1'b0,4'd5,1'b1,1'b1,4'b0011,4'b0011};
    tbl[4]  = '{1'b1,1'b1,4'd0,4'd5,4'd0,1'b0,1'b0,4'd5,1'b1,1'b0,4'b1001,4'b0000};
    tbl[5]  = '{1'b1,1'b0,4'd0,4'd5,4'd0,1'b0,1'b0,4'd5,1'b1,1'b0,4'b0000,4'b0000};
    tbl[6]  = '{1'b0,1'b0,4'd3,4'd0,4'd3,1'b1,1'b1,4'd0,1'b0,1'b0,4'b0000,4'b0000};
    tbl[7]  = '{1'b1,1'b0,4'd3,4'd0,4'd3,1'b0,1'b1,4'd0,1'b0,1'b0,4'b0000,4'b0000};
    tbl[8]  = '{1'b0,1'b0,4'd0,4'd0,4'd0,1'b0,1'b0,4'd0,1'b0,1'b1,4'b0011,4'b0011};
    tbl[9]  = '{1'b1,1'b1,4'd1,4'd7,4'd7,1'b1,1'b1,4'd0,1'b0,1'b0,4'b1001,4'b1001};
    tbl[10] = '{1'b1,1'b0,4'd2,4'd0,4'd3,1'b1,1'b0,4'd4,1'b1,1'b0,4'b0000,4'b0000};

    // Reset with hostile inputs present: all controls must read low.
    clear_inputs();
    branch_taken = 1; mem_req = 1; load_use_hz();
    rst = 1;
    #3;
    chk("rst_outs", int'(outs), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_stall", int'(stall_count), 0);
    @(negedge clk); @(negedge clk);
    chk("rst_held_outs", int'(outs), 0);
    rst = 0;
    clear_inputs();

    // Combinational hazard/branch table in RUN, stall counter tracked per vector.
    for (int i = 0; i <= 10; i++) begin
      logic [3:0] e;
      id_valid = tbl[i].v; id_two_src = tbl[i].two;
      id_src1 = tbl[i].s1; id_src2 = tbl[i].s2;
      exe_dest = tbl[i].ed; exe_wb_en = tbl[i].ewb; exe_mem_r_en = tbl[i].emr;
      mem_dest = tbl[i].md; mem_wb_en = tbl[i].mwb; branch_taken = tbl[i].br;
`ifdef FORWARDING_EN
      e = tbl[i].e_fwd;
`else
      e = tbl[i].e_full;
`endif
      #1;
      chk($sformatf("vec%0d_outs", i), int'(outs), int'(e));
      @(negedge clk);
      if (e == 4'b1001) exp_stall++;
      chk($sformatf("vec%0d_stall", i), int'(stall_count), exp_stall);
      chk($sformatf("vec%0d_state", i), int'(state), 0);
    end
    clear_inputs();

    // Memory access: request cycle plus three wait cycles frozen, then release.
    mem_req = 1;
    #1;
    chk("memA_req_outs", int'(outs), 4'b1100);
    chk("memA_req_state", int'(state), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_req = 0;
      #1;
      chk($sformatf("memA_wait%0d_outs", k), int'(outs), 4'b1100);
      chk($sformatf("memA_wait%0d_state", k), int'(state), 1);
    end
    @(negedge clk);
    mem_ready = 1;
    #1;
    chk("memA_rel_outs", int'(outs), 0);
    chk("memA_rel_state", int'(state), 1);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("memA_back_state", int'(state), 0);
    chk("memA_stall", int'(stall_count), exp_stall);

    // Branch held through a wait: flushes appear only in the release cycle.
    mem_req = 1;
    @(negedge clk);
    mem_req = 0; branch_taken = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("memB_wait%0d_outs", k), int'(outs), 4'b1100);
      @(negedge clk);
    end
    mem_ready = 1;
    #1;
    chk("memB_rel_outs", int'(outs), 4'b0011);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("memB_back_state", int'(state), 0);
    chk("memB_stall", int'(stall_count), exp_stall);

    // Load-use hazard present on the release cycle becomes a counted bubble.
    mem_req = 1;
    @(negedge clk);
    mem_req = 0;
    #1;
    chk("memC_wait_state", int'(state), 1);
    @(negedge clk);
    mem_ready = 1; load_use_hz();
    #1;
    chk("memC_rel_outs", int'(outs), 4'b1001);
    @(negedge clk);
    exp_stall++;
    chk("memC_stall", int'(stall_count), exp_stall);
    clear_inputs();

    // Sustained hazard for 18 cycles: counter pins at all-ones.
    load_use_hz();
    for (int k = 0; k < 18; k++) @(negedge clk);
    chk("sat_stall", int'(stall_count), 15);
    #1;
    chk("sat_outs", int'(outs), 4'b1001);
    clear_inputs();

    // Timeout: four unanswered wait cycles lead to a sticky FAULT.
    mem_req = 1;
    @(negedge clk);
    mem_req = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("to_wait%0d_state", k), int'(state), 1);
      chk($sformatf("to_wait%0d_fault", k), int'(fault), 0);
      @(negedge clk);
    end
    #1;
    chk("to_state", int'(state), 2);
    chk("to_fault", int'(fault), 1);
    chk("to_outs", int'(outs), 4'b1100);
    mem_ready = 1; branch_taken = 1;
    @(negedge clk);
    #1;
    chk("to_sticky_state", int'(state), 2);
    chk("to_sticky_outs", int'(outs), 4'b1100);
    rst = 1;
    #1;
    chk("to_rst_state", int'(state), 0);
    chk("to_rst_fault", int'(fault), 0);
    chk("to_rst_outs", int'(outs), 0);
    chk("to_rst_stall", int'(stall_count), 0);
    @(negedge clk);
    rst = 0;
    clear_inputs();
    #1;
    chk("post_rst_outs", int'(outs), 0);

    // Reset asserted mid-wait returns straight to RUN.
    mem_req = 1;
    @(negedge clk);
    mem_req = 0;
    #1;
    chk("midrst_wait_state", int'(state), 1);
    #2;
    rst = 1;
    #1;
    chk("midrst_state", int'(state), 0);
    chk("midrst_outs", int'(outs), 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("midrst_after_state", int'(state), 0);
    chk("midrst_after_outs", int'(outs), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
